exhaustive_vector_gen: RTL and testbench



---
 rtl/exhaustive_vector_gen.sv | 155 +++++++++++++++
 tb/tb_exhaustive_vector_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_gen.sv
// Exhaustive stimulus generator and checker for small combinational blocks.
// Walks every input vector in binary or Gray order and scores the DUT against EXPECT.
module exhaustive_vector_gen #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 20,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_gray,
  output logic [N_IN-1:0]  vec,
  output logic             vec_valid,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = 1;
  localparam logic [N_IN-1:0] IDX_LAST  = '1;
  localparam logic [N_IN-1:0] IDX_ONE   = 1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             gray_q, gray_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  fev_q, fev_d;
  logic             fvalid_q, fvalid_d;

  logic             sample;
  logic             fail;
  logic [N_OUT-1:0] exp_out;
  logic [N_IN-1:0]  idx_nx;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    gray_d      = gray_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    mismatch_d  = 1'b0;
    err_d       = err_q;
    fev_d       = fev_q;
    fvalid_d    = fvalid_q;
    idx_nx      = idx_q + IDX_ONE;
    // EXPECT is indexed by the driven vector, which differs from idx in Gray mode
    exp_out     = EXPECT[int'(vec_q)*N_OUT +: N_OUT];
    sample      = (state_q == DRIVE) && (hold_q == HOLD_LAST);
    fail        = sample && (dut_out != exp_out);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          idx_d       = '0;
          hold_d      = '0;
          gray_d      = mode_gray;
          vec_d       = '0;
          vec_valid_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = '0;
          fvalid_d    = 1'b0;
        end
      end
      DRIVE: begin
        hold_d = hold_q + HOLD_ONE;
        if (sample) begin
          hold_d = '0;
          if (fail) begin
            mismatch_d = 1'b1;
            err_d      = err_q + ERR_ONE;
            if (!fvalid_q) begin
              fev_d    = vec_q;
              fvalid_d = 1'b1;
            end
          end
          if (idx_q != IDX_LAST) begin
            idx_d = idx_nx;
            vec_d = gray_q ? (idx_nx ^ (idx_nx >> 1)) : idx_nx;
          end else begin
            state_d     = DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            vec_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      gray_q      <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= '0;
      fev_q       <= '0;
      fvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      gray_q      <= gray_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fvalid_q    <= fvalid_d;
    end
  end

  assign vec             = vec_q;
  assign vec_valid       = vec_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign mismatch        = mismatch_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fvalid_q;

endmodule

// File: tb/tb_exhaustive_vector_gen.sv
// Bench for exhaustive_vector_gen: three configurations checked
// cycle by cycle against an order/fault model built from queues.
module tb_exhaustive_vector_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_r;
  logic        mode;
  int          sel;
  logic [15:0] fault;
  int          total;
  int          bad;

  function automatic logic [1:0] f4(input logic [3:0] v);
    return {(v[3] & v[2]) | v[1], v[3] ^ v[0]};
  endfunction

  function automatic logic [31:0] build_exp4();
    logic [31:0] r;
    r = '0;
    for (int v = 0; v < 16; v++) r[v*2 +: 2] = f4(4'(v));
    return r;
  endfunction

  localparam logic [31:0] EXP4 = build_exp4();

  logic [3:0] vec_a, fev_a, vec_b, fev_b;
  logic [1:0] vec_c, fev_c, dout_a, dout_b;
  logic [4:0] err_a, err_b;
  logic [2:0] err_c;
  logic       dout_c;
  logic       vv_a, busy_a, done_a, mm_a, fv_a;
  logic       vv_b, busy_b, done_b, mm_b, fv_b;
  logic       vv_c, busy_c, done_c, mm_c, fv_c;

  assign dout_a = f4(vec_a) ^ {1'b0, fault[vec_a]};
  assign dout_b = f4(vec_b) ^ {1'b0, fault[vec_b]};
  assign dout_c = vec_c[1] & vec_c[0];

  exhaustive_vector_gen #(.N_IN(4), .N_OUT(2), .HOLD(20), .EXPECT(EXP4)) u_a (
    .clk(clk), .rst(rst), .start(start_r && sel == 0), .mode_gray(mode),
    .vec(vec_a), .vec_valid(vv_a), .dut_out(dout_a), .busy(busy_a),
    .done(done_a), .mismatch(mm_a), .err_count(err_a),
    .first_err_vec(fev_a), .first_err_valid(fv_a));

  exhaustive_vector_gen #(.N_IN(4), .N_OUT(2), .HOLD(1), .EXPECT(EXP4)) u_b (
    .clk(clk), .rst(rst), .start(start_r && sel == 1), .mode_gray(mode),
    .vec(vec_b), .vec_valid(vv_b), .dut_out(dout_b), .busy(busy_b),
    .done(done_b), .mismatch(mm_b), .err_count(err_b),
    .first_err_vec(fev_b), .first_err_valid(fv_b));

  exhaustive_vector_gen #(.N_IN(2), .N_OUT(1), .HOLD(3), .EXPECT(4'b0110)) u_c (
    .clk(clk), .rst(rst), .start(start_r && sel == 2), .mode_gray(mode),
    .vec(vec_c), .vec_valid(vv_c), .dut_out(dout_c), .busy(busy_c),
    .done(done_c), .mismatch(mm_c), .err_count(err_c),
    .first_err_vec(fev_c), .first_err_valid(fv_c));

  logic [31:0] o_vec, o_err, o_fev;
  logic        o_vv, o_busy, o_done, o_mm, o_fv;

  always_comb begin
    o_vec = '0; o_err = '0; o_fev = '0;
    o_vv = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_mm = 1'b0; o_fv = 1'b0;
    case (sel)
      0: begin
        o_vec = 32'(vec_a); o_err = 32'(err_a); o_fev = 32'(fev_a);
        o_vv = vv_a; o_busy = busy_a; o_done = done_a; o_mm = mm_a; o_fv = fv_a;
      end
      1: begin
        o_vec = 32'(vec_b); o_err = 32'(err_b); o_fev = 32'(fev_b);
        o_vv = vv_b; o_busy = busy_b; o_done = done_b; o_mm = mm_b; o_fv = fv_b;
      end
      default: begin
        o_vec = 32'(vec_c); o_err = 32'(err_c); o_fev = 32'(fev_c);
        o_vv = vv_c; o_busy = busy_c; o_done = done_c; o_mm = mm_c; o_fv = fv_c;
      end
    endcase
  end

  // Does the lab DUT disagree with the truth table at input v?
  function automatic bit fails(input int s, input int v);
    bit a, b;
    if (s == 2) begin
      a = v[1]; b = v[0];
      return (a ^ b) != (a & b);
    end
    return fault[v];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int s, input string tag);
    sel = s;
    #1;
    chk({tag, ":vec"}, o_vec, 0);
    chk({tag, ":vv"}, 32'(o_vv), 0);
    chk({tag, ":busy"}, 32'(o_busy), 0);
    chk({tag, ":done"}, 32'(o_done), 0);
    chk({tag, ":mm"}, 32'(o_mm), 0);
    chk({tag, ":err"}, o_err, 0);
    chk({tag, ":fev"}, o_fev, 0);
    chk({tag, ":fv"}, 32'(o_fv), 0);
  endtask

  task automatic run(input int s, input bit g, input int nv, input int h,
                     input bit poke, input int abort_at);
    int order[$];
    int ne, fvec, j, last;
    bit fvld;
    string t;
    for (int i = 0; i < nv; i++) order.push_back(g ? (i ^ (i >> 1)) : i);
    last = nv * h;
    @(negedge clk);
    sel = s; mode = g; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int c = 0; c <= last; c++) begin
      j = c / h;
      ne = 0; fvld = 0; fvec = 0;
      for (int k = 0; k < j; k++) begin
        if (fails(s, order[k])) begin
          ne++;
          if (!fvld) begin fvld = 1; fvec = order[k]; end
        end
      end
      t = $sformatf("s%0d c%0d", s, c);
      chk({t, ":vec"}, o_vec, 32'((c < last) ? order[j] : order[nv-1]));
      chk({t, ":vv"}, 32'(o_vv), 32'(c < last));
      chk({t, ":busy"}, 32'(o_busy), 32'(c < last));
      chk({t, ":done"}, 32'(o_done), 32'(c == last));
      chk({t, ":mm"}, 32'(o_mm),
          32'(c > 0 && c % h == 0 && fails(s, order[j-1])));
      chk({t, ":err"}, o_err, 32'(ne));
      chk({t, ":fv"}, 32'(o_fv), 32'(fvld));
      if (fvld) chk({t, ":fev"}, o_fev, 32'(fvec));
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(s, "abort");
        return;
      end
      if (c < last) begin
        if (poke && c < last - 1) begin
          start_r = ($urandom_range(0, 5) == 0);
          mode = 1'($urandom_range(0, 1));
        end else begin
          start_r = 1'b0;
        end
        @(negedge clk);
      end
    end
    start_r = 1'b0;
    @(negedge clk);
    t = $sformatf("s%0d hold", s);
    chk({t, ":done"}, 32'(o_done), 1);
    chk({t, ":busy"}, 32'(o_busy), 0);
    chk({t, ":mm"}, 32'(o_mm), 0);
    chk({t, ":vec"}, o_vec, 32'(order[nv-1]));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start_r = 1'b0; mode = 1'b0; sel = 0; fault = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) check_reset(s, "rst");
    rst = 1'b0;

    run(0, 0, 16, 20, 0, -1);
    fault = 16'h0400;
    run(0, 0, 16, 20, 1, -1);
    run(0, 0, 16, 20, 0, -1);
    run(1, 1, 16, 1, 0, -1);
    run(0, 0, 16, 20, 0, 5 * 20 + 3);
    run(0, 0, 16, 20, 0, -1);
    fault = '0;
    run(2, 0, 4, 3, 1, -1);
    run(2, 1, 4, 3, 0, -1);

    for (int r = 0; r < 6; r++) begin
      fault = 16'($urandom);
      run(1, 1'($urandom_range(0, 1)), 16, 1, 1, -1);
    end
    fault = 16'($urandom);
    run(0, 1, 16, 20, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
